requant_vector_unit: RTL and testbench
======================================

REQUANT_VECTOR_UNIT -- requirements
Module: requant_vector_unit

Interface
REQ-001 SHALL have parameter LANES, default 8, the number of parallel lanes per beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the signed output width per lane.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, the signed accumulator width per lane.
REQ-004 SHALL have parameter BIAS_WIDTH, default 32, the signed bias width per lane.
REQ-005 SHALL have parameter MULT_WIDTH, default 32, the signed per-channel multiplier width.
REQ-006 SHALL have parameter SHIFT_WIDTH, default 6, the unsigned per-channel right-shift width.
REQ-007 SHALL have parameter NUM_CH, default 64, the channel table depth; CH_W = clog2(NUM_CH).
REQ-008 SHALL have ports, in order: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-009 SHALL have cfg_we in 1 (table write strobe), cfg_addr in CH_W, cfg_mult in MULT_WIDTH (signed), and cfg_shift in SHIFT_WIDTH.
REQ-010 SHALL have zp in 32 (signed output zero point, quasi-static) and relu_en in 1 (quasi-static).
REQ-011 SHALL have s_valid in 1, s_ready out 1, s_ch in CH_W, s_acc in LANES*ACC_WIDTH, and s_bias in LANES*BIAS_WIDTH, with lane i at bits [i*W +: W].
REQ-012 SHALL have m_valid out 1, m_ready in 1, m_ch out CH_W, m_data out LANES*DATA_WIDTH, and busy out 1.

Function
REQ-013 SHALL accept a beat when s_valid&&s_ready and emit it when m_valid&&m_ready; beats SHALL leave in order with no loss or duplication.
REQ-014 SHALL implement a 4-stage pipeline: S1 sum = acc+bias (ACC_WIDTH+1 bits) plus table read; S2 product = sum*mult (ACC_WIDTH+MULT_WIDTH+1 bits); S3 round, shift and add zp; S4 clamp into the output register.
REQ-015 SHALL have a latency of exactly 4 cycles from the acceptance edge to m_valid when m_ready is held high; throughput SHALL be 1 beat/cycle.
REQ-016 SHALL use a global stall: s_ready = !m_valid || m_ready; while stalled, every stage register, m_data and m_ch SHALL hold.
REQ-017 SHALL round half toward +inf: for shift s>0, result = (product + 2^(s-1)) >>> s; for s==0, result = product; all arithmetic SHALL be signed with no intermediate truncation.
REQ-018 SHALL clamp with hi = 2^(DATA_WIDTH-1)-1 and lo = -2^(DATA_WIDTH-1); when relu_en=1, lo = max(lo, min(zp, hi)).
REQ-019 SHALL hold a table of NUM_CH entries {mult, shift}, written on a clk edge when cfg_we=1.
REQ-020 SHALL use the old table value for a beat accepted on the same edge as a write to its channel; beats accepted on later edges SHALL use the new value.
REQ-021 SHALL carry s_ch unchanged to m_ch alongside its beat.
REQ-022 SHALL assert busy whenever any stage holds a valid beat.
REQ-023 SHALL treat zp and relu_en changes as taking effect only for beats in S3/S4 at the time; software SHALL change them only when busy=0.

Reset
REQ-024 SHALL, while rst_n=0, clear all stage valids, m_valid, busy, m_data and m_ch to 0, and clear every table entry to mult=0, shift=0.
REQ-025 SHALL, on reset asserted mid-operation, discard in-flight beats; no beat accepted before reset SHALL appear afterwards.
REQ-026 SHALL have s_ready=1 on the first cycle after reset release.

Verification
REQ-027 SHALL cover basic: ch3 = {mult=2^30, shift=31}, zp=-5, all lanes acc=100, bias=-20 -> m_data lanes = 35, m_ch=3, m_valid exactly 4 cycles after acceptance.
REQ-028 SHALL cover rounding: ch0 = {1, 1}, zp=0, lane0 acc=3, lane1 acc=-3, lane2 acc=1, bias=0 -> lanes 2, -1, 1; with shift=0 -> 3, -3, 1.
REQ-029 SHALL cover saturation and ReLU: ch1 = {2^30, 31}, acc=1000 -> 127; acc=-1000 -> -128; with relu_en=1 and zp=10, acc=-1000 -> 10.
REQ-030 SHALL cover backpressure: stream 20 beats with m_ready toggled pseudo-randomly -> all 20 beats are received in order, unchanged, and s_ready always equals !m_valid||m_ready.
REQ-031 SHALL cover cfg during traffic: a write of ch2 on the same edge as a ch2 beat -> that beat uses the old mult and the next ch2 beat uses the new mult.
REQ-032 SHALL cover reset mid-stream: assert rst_n=0 with 3 beats in flight -> m_valid=0, busy=0 and all table entries read 0; after release, only new beats emerge.

Source files
------------

// File: rtl/requant_vector_unit.sv
// Requantisation vector unit: adds bias to wide accumulators, scales by a
// per-channel multiplier, rounds half toward +inf while shifting, adds the
// output zero point and clamps (optionally ReLU) into narrow signed lanes.
// Four register stages with one global stall; a beat accepted on edge N is
// in S1 during the first cycle after N and on m_data in the fourth.
module requant_vector_unit #(
    parameter int LANES       = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 32,
    parameter int MULT_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int NUM_CH      = 64,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [CH_W-1:0]                cfg_addr,
    input  logic signed [MULT_WIDTH-1:0]   cfg_mult,
    input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
    input  logic signed [31:0]             zp,
    input  logic                           relu_en,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [CH_W-1:0]                s_ch,
    input  logic [LANES*ACC_WIDTH-1:0]     s_acc,
    input  logic [LANES*BIAS_WIDTH-1:0]    s_bias,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CH_W-1:0]                m_ch,
    output logic [LANES*DATA_WIDTH-1:0]    m_data,
    output logic                           busy
);

    // Widths grow at each step so no intermediate result is ever truncated
    localparam int SUM_W  = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
    localparam int PROD_W = SUM_W + MULT_WIDTH;
    localparam int RND_W  = PROD_W + 1;
    localparam int RES_W  = ((RND_W > 32) ? RND_W : 32) + 1;

    localparam logic signed [RES_W-1:0] HI =
        {{(RES_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RES_W-1:0] LO =
        {{(RES_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [SHIFT_WIDTH-1:0] SHIFT_ONE = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};

    logic signed [MULT_WIDTH-1:0]  mult_tab_q  [NUM_CH];
    logic signed [MULT_WIDTH-1:0]  mult_tab_d  [NUM_CH];
    logic [SHIFT_WIDTH-1:0]        shift_tab_q [NUM_CH];
    logic [SHIFT_WIDTH-1:0]        shift_tab_d [NUM_CH];

    logic                          s1_valid_q, s1_valid_d;
    logic                          s2_valid_q, s2_valid_d;
    logic                          s3_valid_q, s3_valid_d;
    logic                          m_valid_q,  m_valid_d;
    logic [CH_W-1:0]               ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d;
    logic [CH_W-1:0]               m_ch_q, m_ch_d;
    logic signed [MULT_WIDTH-1:0]  mult1_q, mult1_d;
    logic [SHIFT_WIDTH-1:0]        shift1_q, shift1_d, shift2_q, shift2_d;

    logic                          advance;
    logic signed [RND_W-1:0]       round_inc;
    logic signed [RES_W-1:0]       zp_ext;
    logic signed [RES_W-1:0]       zp_cap;
    logic signed [RES_W-1:0]       lo_eff;

    // The whole pipeline moves only when the output slot is free or draining
    assign advance = !m_valid_q || m_ready;
    assign s_ready = advance;
    assign m_valid = m_valid_q;
    assign m_ch    = m_ch_q;
    assign busy    = s1_valid_q || s2_valid_q || s3_valid_q || m_valid_q;
    assign zp_ext  = RES_W'(zp);

    // Table write; S1 reads the registered copy so a same-edge write is not seen
    always_comb begin
        mult_tab_d  = mult_tab_q;
        shift_tab_d = shift_tab_q;
        if (cfg_we) begin
            mult_tab_d[cfg_addr]  = cfg_mult;
            shift_tab_d[cfg_addr] = cfg_shift;
        end
    end

    // Channel table storage, cleared to {0,0} on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mult_tab_q[c]  <= '0;
                shift_tab_q[c] <= '0;
            end
        end else begin
            mult_tab_q  <= mult_tab_d;
            shift_tab_q <= shift_tab_d;
        end
    end

    // Valid, channel and per-beat scale parameters travel with the data
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        m_valid_d  = m_valid_q;
        ch1_d      = ch1_q;
        ch2_d      = ch2_q;
        ch3_d      = ch3_q;
        m_ch_d     = m_ch_q;
        mult1_d    = mult1_q;
        shift1_d   = shift1_q;
        shift2_d   = shift2_q;
        if (advance) begin
            s1_valid_d = s_valid;
            ch1_d      = s_ch;
            mult1_d    = mult_tab_q[s_ch];
            shift1_d   = shift_tab_q[s_ch];
            s2_valid_d = s1_valid_q;
            ch2_d      = ch1_q;
            shift2_d   = shift1_q;
            s3_valid_d = s2_valid_q;
            ch3_d      = ch2_q;
            m_valid_d  = s3_valid_q;
            m_ch_d     = ch3_q;
        end
    end

    // Control registers; reset discards every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            m_valid_q  <= 1'b0;
            ch1_q      <= '0;
            ch2_q      <= '0;
            ch3_q      <= '0;
            m_ch_q     <= '0;
            mult1_q    <= '0;
            shift1_q   <= '0;
            shift2_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            m_valid_q  <= m_valid_d;
            ch1_q      <= ch1_d;
            ch2_q      <= ch2_d;
            ch3_q      <= ch3_d;
            m_ch_q     <= m_ch_d;
            mult1_q    <= mult1_d;
            shift1_q   <= shift1_d;
            shift2_q   <= shift2_d;
        end
    end

    // Half-LSB rounding constant shared by all lanes; a zero shift adds nothing
    always_comb begin
        round_inc = '0;
        if (shift2_q != '0) begin
            round_inc = RND_W'(1) << (shift2_q - SHIFT_ONE);
        end
    end

    // Lower clamp bound: ReLU raises it to the zero point, capped at the top
    always_comb begin
        zp_cap = (zp_ext > HI) ? HI : zp_ext;
        lo_eff = LO;
        if (relu_en && (zp_cap > LO)) begin
            lo_eff = zp_cap;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [ACC_WIDTH-1:0]  acc_in;
        logic signed [BIAS_WIDTH-1:0] bias_in;
        logic signed [SUM_W-1:0]      sum_q, sum_d;
        logic signed [PROD_W-1:0]     prod_q, prod_d;
        logic signed [RND_W-1:0]      rnd_sum;
        logic signed [RND_W-1:0]      rnd_val;
        logic signed [RES_W-1:0]      res_q, res_d;
        logic [DATA_WIDTH-1:0]        data_q, data_d;

        assign acc_in  = s_acc[i*ACC_WIDTH +: ACC_WIDTH];
        assign bias_in = s_bias[i*BIAS_WIDTH +: BIAS_WIDTH];
        assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;

        // Lane datapath: bias add, scale, round/shift/zero-point, clamp
        always_comb begin
            sum_d   = sum_q;
            prod_d  = prod_q;
            res_d   = res_q;
            data_d  = data_q;
            rnd_sum = RND_W'(prod_q) + round_inc;
            rnd_val = rnd_sum >>> shift2_q;
            if (advance) begin
                sum_d  = SUM_W'(acc_in) + SUM_W'(bias_in);
                prod_d = PROD_W'(sum_q) * PROD_W'(mult1_q);
                res_d  = RES_W'(rnd_val) + zp_ext;
                if (res_q > HI) begin
                    data_d = HI[DATA_WIDTH-1:0];
                end else if (res_q < lo_eff) begin
                    data_d = lo_eff[DATA_WIDTH-1:0];
                end else begin
                    data_d = res_q[DATA_WIDTH-1:0];
                end
            end
        end

        // Lane stage registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q  <= '0;
                prod_q <= '0;
                res_q  <= '0;
                data_q <= '0;
            end else begin
                sum_q  <= sum_d;
                prod_q <= prod_d;
                res_q  <= res_d;
                data_q <= data_d;
            end
        end
    end

endmodule

// File: tb/tb_requant_vector_unit.sv
// Directed bench for requant_vector_unit: a table of single-beat vectors with
// hand-computed lane results, then sequences for backpressure, table writes
// during traffic and reset with beats in flight.
module tb_requant_vector_unit;

    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int CHW   = 6;
    localparam int P30   = 32'h4000_0000;
    localparam int N30   = -32'h4000_0000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cfg_we;
    logic [CHW-1:0]        cfg_addr;
    logic signed [31:0]    cfg_mult;
    logic [5:0]            cfg_shift;
    logic signed [31:0]    zp;
    logic                  relu_en;
    logic                  s_valid;
    logic                  s_ready;
    logic [CHW-1:0]        s_ch;
    logic [LANES*32-1:0]   s_acc;
    logic [LANES*32-1:0]   s_bias;
    logic                  m_valid;
    logic                  m_ready;
    logic [CHW-1:0]        m_ch;
    logic [LANES*DW-1:0]   m_data;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]         ch;
        logic signed [31:0] a0, a1, a2, ar;
        logic signed [31:0] bias;
        logic signed [31:0] zp;
        logic               relu;
        logic signed [31:0] e0, e1, e2, er;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    requant_vector_unit #(
        .LANES(8), .DATA_WIDTH(8), .ACC_WIDTH(32), .BIAS_WIDTH(32),
        .MULT_WIDTH(32), .SHIFT_WIDTH(6), .NUM_CH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .zp(zp), .relu_en(relu_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_acc(s_acc), .s_bias(s_bias),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_data(m_data), .busy(busy)
    );

    function automatic vec_t mk_vec(input int ch, input int a0, input int a1, input int a2,
                                    input int ar, input int bias, input int zpv, input bit relu,
                                    input int e0, input int e1, input int e2, input int er);
        vec_t v;
        v.ch = ch[7:0];
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.ar = ar;
        v.bias = bias; v.zp = zpv; v.relu = relu;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.er = er;
        return v;
    endfunction

    function automatic logic [63:0] pack_exp(input int e0, input int e1, input int e2, input int er);
        logic [63:0] r;
        int e;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : er;
            r[i*DW +: DW] = e[7:0];
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input int ch, input int a0, input int a1, input int a2,
                              input int ar, input int bias);
        int a;
        for (int i = 0; i < LANES; i++) begin
            a = (i == 0) ? a0 : (i == 1) ? a1 : (i == 2) ? a2 : ar;
            s_acc[i*32 +: 32]  = a;
            s_bias[i*32 +: 32] = bias;
        end
        s_ch = ch[CHW-1:0];
    endtask

    task automatic cfg_write(input int addr, input int mult, input int shift);
        cfg_we    = 1'b1;
        cfg_addr  = addr[CHW-1:0];
        cfg_mult  = mult;
        cfg_shift = shift[5:0];
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    // One beat through an idle pipeline: latency, channel, lanes, then idle again
    task automatic apply_stimulus(input string name, input vec_t v);
        int cyc;
        zp      = v.zp;
        relu_en = v.relu;
        m_ready = 1'b1;
        drive_beat(int'(v.ch), v.a0, v.a1, v.a2, v.ar, v.bias);
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        cyc = 1;
        while (!m_valid && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_output({name, "_latency"}, 64'(cyc), 64'd4);
        check_output({name, "_ch"}, 64'(m_ch), 64'(v.ch[CHW-1:0]));
        check_output({name, "_data"}, m_data, pack_exp(v.e0, v.e1, v.e2, v.er));
        @(posedge clk); #1;
        check_output({name, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int tx, rx, cyc, got, seen;
        logic fire_in, fire_out;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mult = '0; cfg_shift = '0;
        zp = '0; relu_en = 1'b0; s_valid = 1'b0; s_ch = '0; s_acc = '0; s_bias = '0;
        m_ready = 1'b1;

        // Outputs while held in reset
        #2;
        check_output("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_m_data", m_data, 64'd0);
        check_output("rst_m_ch", 64'(m_ch), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check_output("rst_s_ready", {63'd0, s_ready}, 64'd1);

        // Channel table: ch5 is deliberately never written
        cfg_write(3, P30, 31);
        cfg_write(0, 1, 1);
        cfg_write(4, 1, 0);
        cfg_write(1, P30, 31);
        cfg_write(6, N30, 31);
        cfg_write(2, P30, 31);
        cfg_write(7, 1, 0);
        cfg_write(8, 1, 0);

        //                 ch   a0     a1     a2     ar     bias   zp  relu e0   e1   e2   er
        vecs[0]  = mk_vec(3,  100,   100,   100,   100,   -20,   -5,  0,  35,  35,  35,  35);
        vecs[1]  = mk_vec(0,  3,     -3,    1,     0,     0,     0,   0,  2,   -1,  1,   0);
        vecs[2]  = mk_vec(4,  3,     -3,    1,     0,     0,     0,   0,  3,   -3,  1,   0);
        vecs[3]  = mk_vec(1,  1000,  1000,  1000,  1000,  0,     0,   0,  127, 127, 127, 127);
        vecs[4]  = mk_vec(1,  -1000, -1000, -1000, -1000, 0,     0,   0,  -128,-128,-128,-128);
        vecs[5]  = mk_vec(1,  -1000, -1000, -1000, -1000, 0,     10,  1,  10,  10,  10,  10);
        vecs[6]  = mk_vec(1,  -1000, -1000, -1000, -1000, 0,     200, 1,  127, 127, 127, 127);
        vecs[7]  = mk_vec(6,  100,   100,   100,   100,   0,     0,   0,  -50, -50, -50, -50);
        vecs[8]  = mk_vec(5,  100,   100,   100,   100,   0,     -5,  0,  -5,  -5,  -5,  -5);
        vecs[9]  = mk_vec(0,  -1,    5,     -5,    0,     0,     0,   0,  0,   3,   -2,  0);
        vecs[10] = mk_vec(4,  3,     -3,    1,     0,     0,     0,   1,  3,   0,   1,   0);
        vecs[11] = mk_vec(4,  127,   128,   -129,  -128,  0,     0,   0,  127, 127, -128,-128);
        vecs[12] = mk_vec(4,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                          32'h7FFF_FFFF, 0, 0, 127, 127, 127, 127);

        for (int v = 0; v < 13; v++) begin
            apply_stimulus($sformatf("vec%0d", v), vecs[v]);
        end

        // Backpressure: 20 identity beats on ch7/ch8 with random m_ready
        $display("[TB] backpressure stream");
        zp = 0; relu_en = 1'b0;
        tx = 0; rx = 0; cyc = 0;
        while (rx < 20 && cyc < 600) begin
            m_ready = 1'($urandom_range(0, 1));
            if (tx < 20) begin
                drive_beat(7 + (tx % 2), tx*5 - 40, tx*5 - 39, tx*5 - 38, tx*5 - 37, 0);
                s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            #1;
            check_output("bp_s_ready", {63'd0, s_ready}, {63'd0, (!m_valid || m_ready)});
            fire_in  = s_valid && s_ready;
            fire_out = m_valid && m_ready;
            if (fire_out) begin
                check_output($sformatf("bp_data%0d", rx), m_data,
                             pack_exp(rx*5 - 40, rx*5 - 39, rx*5 - 38, rx*5 - 37));
                check_output($sformatf("bp_ch%0d", rx), 64'(m_ch), 64'(7 + (rx % 2)));
                rx++;
            end
            if (fire_in) tx++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check_output("bp_count", 64'(rx), 64'd20);

        // Table write on the same edge as a ch2 beat: old scale, then new scale
        $display("[TB] cfg during traffic");
        repeat (4) begin @(posedge clk); #1; end
        zp = 0; relu_en = 1'b0;
        drive_beat(2, 100, 100, 100, 100, 0);
        s_valid = 1'b1;
        cfg_write(2, 1, 0);
        drive_beat(2, 100, 100, 100, 100, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        got = 0; cyc = 0;
        while (got < 2 && cyc < 15) begin
            if (m_valid) begin
                if (got == 0) check_output("cfg_old", m_data, pack_exp(50, 50, 50, 50));
                else          check_output("cfg_new", m_data, pack_exp(100, 100, 100, 100));
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_output("cfg_count", 64'(got), 64'd2);

        // Reset with three beats in flight
        $display("[TB] reset mid-stream");
        repeat (2) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_beat(7, 11 + k, 12 + k, 13 + k, 14 + k, 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check_output("mid_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("mid_m_valid", {63'd0, m_valid}, 64'd0);
        check_output("mid_busy", {63'd0, busy}, 64'd0);
        check_output("mid_m_data", m_data, 64'd0);
        check_output("mid_m_ch", 64'(m_ch), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check_output("mid_s_ready", {63'd0, s_ready}, 64'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_valid) seen++;
            @(posedge clk); #1;
        end
        check_output("mid_no_stale", 64'(seen), 64'd0);
        apply_stimulus("mid_tab1", mk_vec(1, 1000, 1000, 1000, 1000, 0, 7, 0, 7, 7, 7, 7));
        apply_stimulus("mid_tab7", mk_vec(7, 50, -50, 20, 30, 0, 7, 0, 7, 7, 7, 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
